dp_ram_be_clr: RTL and testbench

- Parametrised successor to the team's 8x256 dual-port synchronous RAM: one write port, one read port, one clock.
- Adds per-byte write enables and a selectable read-during-write policy.
- Adds a configurable 1- or 2-cycle read latency with a valid strobe.
- Adds an FSM-driven memory clear, run after reset or on request, with a busy flag.
- Used as the generic scratch/buffer memory behind FIFOs and packet buffers.

---
 rtl/dp_ram_pkg.sv | 16 +
 rtl/dp_ram_rd_pipe.sv | 46 ++++
 rtl/dp_ram_be_clr.sv | 140 ++++++++++++++
 tb/tb_dp_ram_be_clr.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM with clear.
package dp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int calc_num_be(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read output register chain (1 or 2 stages) carrying data, valid and error.
module dp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_i,
    input  logic                  err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  vld_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [RD_LATENCY-1:0] vld_pipe_q;
    logic [RD_LATENCY-1:0] err_pipe_q;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe_q;

    // Data and error only advance with a valid so data_o holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            err_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= vld_i;
            if (vld_i) begin
                err_pipe_q[0] <= err_i;
                dat_pipe_q[0] <= data_i;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                if (vld_pipe_q[s-1]) begin
                    err_pipe_q[s] <= err_pipe_q[s-1];
                    dat_pipe_q[s] <= dat_pipe_q[s-1];
                end
            end
        end
    end

    assign vld_o  = vld_pipe_q[RD_LATENCY-1];
    assign err_o  = err_pipe_q[RD_LATENCY-1];
    assign data_o = dat_pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/dp_ram_be_clr.sv
// Dual-port RAM with byte enables, read-during-write policy, 1/2-cycle read
// latency and an FSM-driven whole-array clear after reset or on request.
module dp_ram_be_clr
    import dp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_W     = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
    localparam int                   NUM_BE     = calc_num_be(DATA_WIDTH, BYTE_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_BE-1:0]     wr_be,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_err
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("dp_ram_be_clr: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH > (2 ** ADDR_WIDTH) || DEPTH < 1) begin : g_bad_depth
        $error("dp_ram_be_clr: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_bw
        $error("dp_ram_be_clr: DATA_WIDTH must be a multiple of BYTE_W");
    end

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    logic                  acc;
    logic                  wr_in_rng, rd_in_rng;
    logic [NUM_BE-1:0]     lane_we;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word_d;
    logic                  rd_vld_d;
    logic                  rd_err_d;

    // A clear request wins over any port activity in the same cycle.
    assign acc       = (state_q == READY) && !clr_req;
    assign wr_in_rng = {1'b0, wr_addr} < DEPTH_W;
    assign rd_in_rng = {1'b0, rd_addr} < DEPTH_W;
    assign lane_we   = (acc && wr_enb && wr_in_rng) ? wr_be : '0;
    assign rd_idx    = rd_in_rng ? rd_addr : '0;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_A) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= CLEAR_VAL;
        end else begin
            for (int b = 0; b < NUM_BE; b++) begin
                if (lane_we[b]) begin
                    mem_q[wr_addr][b*BYTE_W +: BYTE_W] <= data_in[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Write-through merges only the lanes actually being written this cycle.
    always_comb begin
        rd_word_d = mem_q[rd_idx];
        if (RDW_MODE == RDW_NEW && wr_addr == rd_addr) begin
            for (int b = 0; b < NUM_BE; b++) begin
                if (lane_we[b]) begin
                    rd_word_d[b*BYTE_W +: BYTE_W] = data_in[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (!rd_in_rng) begin
            rd_word_d = '0;
        end
    end

    assign rd_vld_d = acc && rd_enb;
    assign rd_err_d = !rd_in_rng;

    dp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (rd_vld_d),
        .err_i  (rd_err_d),
        .data_i (rd_word_d),
        .vld_o  (rd_valid),
        .err_o  (rd_err),
        .data_o (data_out)
    );

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Directed bench: three RAM configurations share one stimulus stream.
module tb_dp_ram_be_clr;

    logic        clk = 1'b0;
    logic        reset, clr_req, wr_enb, rd_enb;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] data_in;

    logic        a_busy, a_vld, a_err, b_busy, b_vld, b_err, c_busy, c_vld, c_err;
    logic [31:0] a_do, b_do, c_do;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_a = '0;

    always #5 clk = ~clk;

    // A: old-data, latency 1. B: write-through, latency 2. C: DEPTH 200.
    dp_ram_be_clr #(.DEPTH(256), .RD_LATENCY(1), .RDW_MODE(0)) u_a (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(a_busy),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(a_do), .rd_valid(a_vld), .rd_err(a_err));
    dp_ram_be_clr #(.DEPTH(256), .RD_LATENCY(2), .RDW_MODE(1)) u_b (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(b_busy),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(b_do), .rd_valid(b_vld), .rd_err(b_err));
    dp_ram_be_clr #(.DEPTH(200), .RD_LATENCY(1), .RDW_MODE(0)) u_c (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(c_busy),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(c_do), .rd_valid(c_vld), .rd_err(c_err));

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        logic        ec_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(input logic we, input logic [7:0] wa, input logic [3:0] be,
                                 input logic [31:0] wd, input logic re, input logic [7:0] ra,
                                 input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] ec, input logic ec_err);
        vec_t v;
        v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra;
        v.ea = ea; v.eb = eb; v.ec = ec; v.ec_err = ec_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after a falling edge; one op, then A/C and B results checked.
    task automatic apply_vec(input vec_t v, input string tag);
        wr_enb = v.we; wr_addr = v.wa; wr_be = v.be; data_in = v.wd;
        rd_enb = v.re; rd_addr = v.ra;
        @(negedge clk);
        wr_enb = 1'b0; rd_enb = 1'b0;
        chk({tag, " a_vld"}, a_vld, v.re);
        chk({tag, " c_vld"}, c_vld, v.re);
        if (v.re) begin
            chk({tag, " a_do"}, a_do, v.ea);
            chk({tag, " a_err"}, a_err, 0);
            chk({tag, " c_do"}, c_do, v.ec);
            chk({tag, " c_err"}, c_err, v.ec_err);
            last_a = v.ea;
        end else begin
            chk({tag, " a_hold"}, a_do, last_a);
        end
        @(negedge clk);
        chk({tag, " b_vld"}, b_vld, v.re);
        chk({tag, " a_vld_late"}, a_vld, 0);
        if (v.re) begin
            chk({tag, " b_do"}, b_do, v.eb);
            chk({tag, " b_err"}, b_err, 0);
        end
    endtask

    task automatic busy_window(output int na, output int nb, output int nc);
        na = 0; nb = 0; nc = 0;
        for (int i = 0; i < 300; i++) begin
            na += int'(a_busy); nb += int'(b_busy); nc += int'(c_busy);
            @(negedge clk);
        end
    endtask

    int na, nb, nc, viol;

    initial begin
        reset = 1'b0; clr_req = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; data_in = '0;

        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'h10, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h05, 4'hF, 32'hAABBCCDD, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h05, 4'h5, 32'h11223344, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'h05, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0));
        vt.push_back(mkv(1, 8'h07, 4'hF, 32'h12345678, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h07, 4'hF, 32'hFFFFFFFF, 1, 8'h07, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'h07, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0));
        vt.push_back(mkv(1, 8'd250, 4'hF, 32'hDEADBEEF, 0, 8'h00, 32'h0,       32'h0,        32'h0,        0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'd250, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,       1));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'd122, 32'h0,       32'h0,        32'h0,        0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'd50,  32'h0,       32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h09, 4'hF, 32'hCAFEF00D, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h09, 4'h0, 32'h12345678, 1, 8'h09, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0));
        vt.push_back(mkv(1, 8'h09, 4'h8, 32'h55667788, 1, 8'h09, 32'hCAFEF00D, 32'h55FEF00D, 32'hCAFEF00D, 0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'h09, 32'h55FEF00D, 32'h55FEF00D, 32'h55FEF00D, 0));
        vt.push_back(mkv(1, 8'd20, 4'hF, 32'h11111111, 1, 8'h05, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0));
        vt.push_back(mkv(1, 8'd199, 4'hF, 32'h0BADC0DE, 0, 8'h00, 32'h0,       32'h0,        32'h0,        0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'd199, 32'h0BADC0DE, 32'h0BADC0DE, 32'h0BADC0DE, 0));
        vt.push_back(mkv(0, 8'h00, 4'h0, 32'h0,        1, 8'd200, 32'h0,       32'h0,        32'h0,        1));
        vt.push_back(mkv(1, 8'h01, 4'hF, 32'h01010101, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h02, 4'hF, 32'h02020202, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));
        vt.push_back(mkv(1, 8'h03, 4'hF, 32'h03030303, 0, 8'h00, 32'h0,        32'h0,        32'h0,        0));

        repeat (3) @(negedge clk);
        chk("rst a_busy", a_busy, 1);
        chk("rst c_busy", c_busy, 1);
        chk("rst a_vld", a_vld, 0);
        chk("rst a_err", a_err, 0);
        chk("rst a_do", a_do, 0);
        chk("rst b_vld", b_vld, 0);
        reset = 1'b1;
        busy_window(na, nb, nc);
        chk("init busy a", na, 256);
        chk("init busy b", nb, 256);
        chk("init busy c", nc, 200);

        foreach (vt[i]) apply_vec(vt[i], $sformatf("v%0d", i));

        // Back-to-back reads of 1,2,3 then a clear request right behind them.
        rd_enb = 1'b1; rd_addr = 8'h01;
        @(negedge clk);
        chk("lat r1 a", a_do, 32'h01010101); chk("lat r1 a_vld", a_vld, 1);
        chk("lat r1 b_vld", b_vld, 0);
        rd_addr = 8'h02;
        @(negedge clk);
        chk("lat r2 a", a_do, 32'h02020202);
        chk("lat r1 b", b_do, 32'h01010101); chk("lat r1 b_vld", b_vld, 1);
        rd_addr = 8'h03;
        @(negedge clk);
        chk("lat r3 a", a_do, 32'h03030303);
        chk("lat r2 b", b_do, 32'h02020202); chk("lat r2 b_vld", b_vld, 1);
        rd_enb = 1'b0; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        chk("lat r3 b", b_do, 32'h03030303); chk("lat r3 b_vld", b_vld, 1);
        chk("lat a_vld idle", a_vld, 0);

        // Reads and a second clr_req issued while busy must do nothing.
        na = 0; nb = 0; nc = 0; viol = 0;
        for (int i = 0; i < 300; i++) begin
            na += int'(a_busy); nb += int'(b_busy); nc += int'(c_busy);
            if (i >= 2 && i < 150) viol += int'(a_vld | b_vld | c_vld);
            rd_enb  = (i >= 1 && i < 100);
            clr_req = (i == 100);
            @(negedge clk);
        end
        rd_enb = 1'b0; clr_req = 1'b0;
        chk("req busy a", na, 256);
        chk("req busy b", nb, 256);
        chk("req busy c", nc, 200);
        chk("no rd during busy", viol, 0);

        apply_vec(mkv(0, 8'h00, 4'h0, 32'h0, 1, 8'h01, 32'h0, 32'h0, 32'h0, 0), "post-clr r1");
        apply_vec(mkv(1, 8'h05, 4'hF, 32'h13572468, 0, 8'h00, 32'h0, 32'h0, 32'h0, 0), "w5");
        apply_vec(mkv(0, 8'h00, 4'h0, 32'h0, 1, 8'h05, 32'h13572468, 32'h13572468, 32'h13572468, 0), "r5");
        apply_vec(mkv(1, 8'd250, 4'hF, 32'h77777777, 0, 8'h00, 32'h0, 32'h0, 32'h0, 0), "w250");

        // Reset asserted with the clear counter at 100.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid a_busy", a_busy, 1);
        reset = 1'b0;
        #1;
        chk("mid rst a_do", a_do, 0);
        chk("mid rst a_vld", a_vld, 0);
        chk("mid rst busy", a_busy, 1);
        @(negedge clk);
        reset = 1'b1;
        busy_window(na, nb, nc);
        chk("mid busy a", na, 256);
        chk("mid busy b", nb, 256);
        chk("mid busy c", nc, 200);
        last_a = '0;
        apply_vec(mkv(0, 8'h00, 4'h0, 32'h0, 1, 8'd250, 32'h0, 32'h0, 32'h0, 1), "post-rst r250");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
